seq_z_decoder: RTL and testbench
================================

Name: seq_z_decoder

Overview:
- Receive-side companion to the three-flop xor/and/or parity encoder (x in, z = XNOR of q_xor, q_and, q_or out).
- Observes the encoder's z stream one sample per encoder step.
- Tracks the set of encoder states consistent with that stream and recovers the x bit that caused each step wherever it is uniquely determined.
- Flags ambiguity, lock, and stream inconsistency; sits in the checker/monitor path next to the encoder.

Parameters:
- KNOWN_INIT, 1, 1: encoder starts in state 000, so the initial candidate mask is 8'b0000_0001. 0: initial mask is all 8 states.
- CNT_W, 16, width of the saturating ambiguous-step and error counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- z_valid  input  1  z_in holds one encoder step this cycle
- z_in  input  1  observed encoder output z
- clr  input  1  synchronous: reload initial mask, clear sticky error and counters
- x_valid  output  1  one-cycle pulse, decision for the step sampled last cycle
- x_dec  output  1  recovered x; meaningful only when x_valid & x_known
- x_known  output  1  all surviving transitions agree on x
- locked  output  1  exactly one candidate state remains
- err  output  1  one-cycle pulse, no candidate survived
- err_sticky  output  1  set by err, cleared by clr or reset
- cand_mask  output  8  current candidate set; bit i = encoder state i
- ambig_cnt  output  CNT_W  steps with x_known=0, saturating
- err_cnt  output  CNT_W  err pulses, saturating

Behaviour:
- State encoding: s[2]=q_or, s[1]=q_and, s[0]=q_xor.
- Encoder next state: q_xor' = x^q_xor; q_and' = x&~q_and; q_or' = x|~q_or.
- Encoder output: z(s) = ~(s[2]^s[1]^s[0]).
- Reset (async, rst_n=0):
  - cand_mask = initial mask (per KNOWN_INIT).
  - All other outputs and counters = 0.
  - locked reflects the mask after reset: 1 when KNOWN_INIT=1, else 0.
- Each cycle with z_valid=1, for every state i set in cand_mask and each x in {0,1}:
  - Compute n = next(i, x).
  - The pair survives if z(n) == z_in.
- New mask = OR of one-hot(n) over all survivors.
- Decision:
  - x_known=1 iff every survivor carries the same x; x_dec = that x.
  - x_known=0 otherwise; x_dec=0.
- Zero survivors:
  - Pulse err; set err_sticky.
  - Increment err_cnt.
  - Reload cand_mask to all 8 states (resync).
  - x_known=0; ambig_cnt is not incremented.
- Output timing:
  - x_valid, x_dec, x_known, err and the mask update are registered, visible the cycle after the z_valid sample.
  - Latency is 1 cycle; throughput is 1 sample per cycle; back-to-back z_valid is legal.
- z_valid=0: mask and counters hold; x_valid=0, err=0.
- locked = popcount(cand_mask)==1, derived from the registered mask.
- ambig_cnt increments on every valid step with survivors>0 and x_known=0.
- Both counters saturate at all-ones; no wrap.
- clr=1 has priority over a simultaneous z_valid: that sample is dropped, the mask reloads, and no x_valid is produced.
- Reset mid-stream discards all history. No back-pressure; the decoder always accepts.

Decomposition:
- Package seq_z_pkg:
  - state type (3-bit)
  - mask type (8-bit)
  - ENC_NEXT function (state, x -> state)
  - ENC_Z function (state -> z)
  - INIT_MASK_KNOWN / INIT_MASK_ALL constants
  - shared with the encoder testbench model.
- One sub-module: seq_z_step, purely combinational. Inputs: mask, z. Outputs: next mask, any_x0, any_x1, empty.
- Top holds the registers, counters and flags.

Test Plan:
- KNOWN_INIT=1, reset, z_valid with z_in=0 -> next cycle x_valid=1, x_known=0, cand_mask=8'b1001_0000, locked=0, ambig_cnt=1.
- Continue with z_in=1 -> x_known=1, x_dec=0, cand_mask=8'b0000_0001, locked=1.
- Alternative second sample z_in=0 -> x_known=0, cand_mask=8'b1001_0010, ambig_cnt=2.
- KNOWN_INIT=1, reset, first sample z_in=1 -> err=1 for one cycle, err_sticky=1, err_cnt=1, cand_mask=8'hFF, x_known=0.
- Random x driving the reference encoder for 10k cycles, z_valid every cycle:
  - Never err.
  - Whenever x_known=1, x_dec equals the encoder's x from that step.
  - The true encoder state is always in cand_mask.
- Mid-stream clr together with z_valid -> no x_valid, mask = initial, err_sticky=0, counters=0.
- Mid-stream rst_n low for one cycle -> same clearing, asynchronous to clk.
- CNT_W=2 with 5 ambiguous steps -> ambig_cnt saturates at 3.

Source files
------------

// File: rtl/seq_z_pkg.sv
// Shared definitions for the xor/and/or parity encoder and its z-stream decoder.
// State bit order: s[2]=q_or, s[1]=q_and, s[0]=q_xor.
package seq_z_pkg;

  typedef logic [2:0] state_t;
  typedef logic [7:0] mask_t;

  localparam mask_t INIT_MASK_KNOWN = 8'b0000_0001;
  localparam mask_t INIT_MASK_ALL   = 8'b1111_1111;

  function automatic state_t ENC_NEXT(input state_t s, input logic x);
    return {x | ~s[2], x & ~s[1], x ^ s[0]};
  endfunction

  // z is the XNOR of all three flops.
  function automatic logic ENC_Z(input state_t s);
    return ~(^s);
  endfunction

endpackage

// File: rtl/seq_z_step.sv
// One decoder step: advances the candidate set by one observed z sample and
// reports which x values are still possible.
module seq_z_step
  import seq_z_pkg::*;
(
  input  mask_t mask,
  input  logic  z,
  output mask_t next_mask,
  output logic  any_x0,
  output logic  any_x1,
  output logic  empty
);

  state_t n0;
  state_t n1;

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latch).
    next_mask = '0;
    any_x0    = 1'b0;
    any_x1    = 1'b0;
    n0        = '0;
    n1        = '0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        n0 = ENC_NEXT(state_t'(i), 1'b0);
        n1 = ENC_NEXT(state_t'(i), 1'b1);
        if (ENC_Z(n0) == z) begin
          next_mask[n0] = 1'b1;
          any_x0        = 1'b1;
        end
        if (ENC_Z(n1) == z) begin
          next_mask[n1] = 1'b1;
          any_x1        = 1'b1;
        end
      end
    end
  end

  assign empty = ~(any_x0 | any_x1);

endmodule

// File: rtl/seq_z_decoder.sv
// Tracks the encoder states consistent with the observed z stream and recovers
// x wherever every surviving transition agrees on it.
module seq_z_decoder
  import seq_z_pkg::*;
#(
  parameter bit KNOWN_INIT = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             z_valid,
  input  logic             z_in,
  input  logic             clr,
  output logic             x_valid,
  output logic             x_dec,
  output logic             x_known,
  output logic             locked,
  output logic             err,
  output logic             err_sticky,
  output logic [7:0]       cand_mask,
  output logic [CNT_W-1:0] ambig_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam mask_t INIT_MASK = KNOWN_INIT ? INIT_MASK_KNOWN : INIT_MASK_ALL;

  mask_t step_mask;
  logic  any_x0;
  logic  any_x1;
  logic  empty;

  seq_z_step u_step (
    .mask      (cand_mask),
    .z         (z_in),
    .next_mask (step_mask),
    .any_x0    (any_x0),
    .any_x1    (any_x1),
    .empty     (empty)
  );

  assign locked = $onehot(cand_mask);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_mask  <= INIT_MASK;
      x_valid    <= 1'b0;
      x_dec      <= 1'b0;
      x_known    <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      ambig_cnt  <= '0;
      err_cnt    <= '0;
    end else if (clr) begin
      // clr wins over a simultaneous sample; that sample is dropped.
      cand_mask  <= INIT_MASK;
      x_valid    <= 1'b0;
      x_dec      <= 1'b0;
      x_known    <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      ambig_cnt  <= '0;
      err_cnt    <= '0;
    end else if (z_valid) begin
      x_valid <= 1'b1;
      if (empty) begin
        // No state explains the stream: resync from the full state set.
        cand_mask  <= INIT_MASK_ALL;
        x_known    <= 1'b0;
        x_dec      <= 1'b0;
        err        <= 1'b1;
        err_sticky <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end else begin
        cand_mask <= step_mask;
        x_known   <= any_x0 ^ any_x1;
        x_dec     <= any_x1 & ~any_x0;
        err       <= 1'b0;
        if (any_x0 && any_x1 && ambig_cnt != '1) ambig_cnt <= ambig_cnt + CNT_W'(1);
      end
    end else begin
      x_valid <= 1'b0;
      err     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_z_decoder.sv
// Scoreboard bench for seq_z_decoder: a set-based reference model predicts each
// step, a monitor compares whenever the DUT presents a decision.
module tb_seq_z_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        z_valid = 1'b0;
  logic        z_in = 1'b0;
  logic        clr = 1'b0;
  logic        x_valid, x_dec, x_known, locked, err, err_sticky;
  logic [7:0]  cand_mask;
  logic [15:0] ambig_cnt, err_cnt;

  logic        s_x_valid, s_x_dec, s_x_known, s_locked, s_err, s_err_sticky;
  logic [7:0]  s_cand_mask;
  logic [1:0]  s_ambig_cnt, s_err_cnt;

  always #5 clk = ~clk;

  seq_z_decoder #(.KNOWN_INIT(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .z_valid(z_valid), .z_in(z_in), .clr(clr),
    .x_valid(x_valid), .x_dec(x_dec), .x_known(x_known), .locked(locked),
    .err(err), .err_sticky(err_sticky), .cand_mask(cand_mask),
    .ambig_cnt(ambig_cnt), .err_cnt(err_cnt)
  );

  seq_z_decoder #(.KNOWN_INIT(1'b1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .z_valid(z_valid), .z_in(z_in), .clr(clr),
    .x_valid(s_x_valid), .x_dec(s_x_dec), .x_known(s_x_known), .locked(s_locked),
    .err(s_err), .err_sticky(s_err_sticky), .cand_mask(s_cand_mask),
    .ambig_cnt(s_ambig_cnt), .err_cnt(s_err_cnt)
  );

  typedef struct {
    logic       known;
    logic       dec;
    logic [7:0] mask;
    logic       err;
    logic       sticky;
    int         ambig;
    int         errs;
    bit         truth;
    logic       tx;
    int         ts;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state.
  logic [7:0] m_mask;
  logic       m_sticky;
  int         m_ambig;
  int         m_errs;
  int         enc_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Encoder rules written bit by bit: xor toggles on x, and-flop sets on x when
  // clear, or-flop sets on x or when currently clear.
  function automatic int tb_next(input int s, input int x);
    int q_xor, q_and, q_or;
    q_xor = (s % 2) ^ x;
    q_and = (x == 1 && ((s / 2) % 2) == 0) ? 1 : 0;
    q_or  = (x == 1 || (s / 4) == 0) ? 1 : 0;
    return q_or * 4 + q_and * 2 + q_xor;
  endfunction

  function automatic int tb_z(input int s);
    int ones;
    ones = (s % 2) + ((s / 2) % 2) + (s / 4);
    return (ones % 2 == 0) ? 1 : 0;
  endfunction

  function automatic int popcount8(input logic [7:0] m);
    int c = 0;
    for (int i = 0; i < 8; i++) if (m[i]) c++;
    return c;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_reset();
    m_mask   = 8'h01;
    m_sticky = 1'b0;
    m_ambig  = 0;
    m_errs   = 0;
  endtask

  task automatic model_step(input int z, output exp_t e);
    int  cands[$];
    logic [7:0] nm;
    bit  saw0, saw1;
    nm = '0; saw0 = 0; saw1 = 0;
    for (int i = 0; i < 8; i++) if (m_mask[i]) cands.push_back(i);
    foreach (cands[k]) begin
      for (int x = 0; x < 2; x++) begin
        int n;
        n = tb_next(cands[k], x);
        if (tb_z(n) == z) begin
          nm[n] = 1'b1;
          if (x == 1) saw1 = 1; else saw0 = 1;
        end
      end
    end
    e.err = 1'b0; e.known = 1'b0; e.dec = 1'b0;
    if (!saw0 && !saw1) begin
      m_errs++;
      m_sticky = 1'b1;
      m_mask   = 8'hFF;
      e.err    = 1'b1;
    end else begin
      m_mask  = nm;
      e.known = (saw0 != saw1);
      e.dec   = saw1 && !saw0;
      if (!e.known) m_ambig++;
    end
    e.mask = m_mask; e.sticky = m_sticky; e.ambig = m_ambig; e.errs = m_errs;
    e.truth = 0; e.tx = 1'b0; e.ts = 0;
  endtask

  task automatic issue(input int z, input bit truth, input int tx, input int ts);
    exp_t e;
    z_valid = 1'b1;
    z_in    = z[0];
    model_step(z, e);
    e.truth = truth; e.tx = tx[0]; e.ts = ts;
    exp_q.push_back(e);
    @(negedge clk);
    z_valid = 1'b0;
  endtask

  task automatic idle();
    z_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    z_valid = 1'b0;
    clr     = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mask", cand_mask, 8'h01);
    check("rst_locked", locked, 1'b1);
    check("rst_x_valid", x_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_sticky", err_sticky, 1'b0);
    check("rst_ambig", ambig_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_x_known", x_known, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every presented decision against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (x_valid === 1'b1 || err === 1'b1)) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_output: x_valid=%b err=%b with nothing pending at %0t", x_valid, err, $time);
        end else begin
          e = exp_q.pop_front();
          check("x_valid", x_valid, 1'b1);
          check("err", err, e.err);
          check("x_known", x_known, e.known);
          check("x_dec", x_dec, e.dec);
          check("cand_mask", cand_mask, e.mask);
          check("locked", locked, popcount8(e.mask) == 1);
          check("err_sticky", err_sticky, e.sticky);
          check("ambig_cnt", ambig_cnt, e.ambig);
          check("err_cnt", err_cnt, e.errs);
          check("sat_ambig_cnt", s_ambig_cnt, sat3(e.ambig));
          check("sat_err_cnt", s_err_cnt, sat3(e.errs));
          if (e.truth) begin
            check("no_err_on_real_stream", err, 1'b0);
            check("true_state_in_mask", cand_mask[e.ts[2:0]], 1'b1);
            if (e.known) check("x_dec_true", x_dec, e.tx);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x;
    model_reset();
    do_reset();

    // First sample z=0 from 000, then z=1 locks back onto 000.
    issue(0, 0, 0, 0);
    check("d1_mask", cand_mask, 8'b1001_0000);
    check("d1_known", x_known, 1'b0);
    check("d1_locked", locked, 1'b0);
    check("d1_ambig", ambig_cnt, 1);
    issue(1, 0, 0, 0);
    check("d2_known", x_known, 1'b1);
    check("d2_dec", x_dec, 1'b0);
    check("d2_mask", cand_mask, 8'b0000_0001);
    check("d2_locked", locked, 1'b1);

    do_reset();
    issue(0, 0, 0, 0);
    issue(0, 0, 0, 0);
    check("d3_known", x_known, 1'b0);
    check("d3_mask", cand_mask, 8'b1001_0010);
    check("d3_ambig", ambig_cnt, 2);

    // z=1 is impossible as the first output from state 000.
    do_reset();
    issue(1, 0, 0, 0);
    check("e_err", err, 1'b1);
    check("e_sticky", err_sticky, 1'b1);
    check("e_err_cnt", err_cnt, 1);
    check("e_mask", cand_mask, 8'hFF);
    check("e_known", x_known, 1'b0);
    idle();
    check("e_err_pulse", err, 1'b0);
    check("e_sticky_hold", err_sticky, 1'b1);
    check("e_mask_hold", cand_mask, 8'hFF);

    // Arbitrary z stream with gaps: exercises resync and error counting.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) idle();
      else issue($urandom_range(0, 1), 0, 0, 0);
    end
    check("sticky_before_clr", err_sticky, m_sticky);

    // clr together with a sample: sample dropped, everything cleared.
    z_valid = 1'b1;
    z_in    = 1'($urandom_range(0, 1));
    clr     = 1'b1;
    model_reset();
    @(negedge clk);
    clr = 1'b0; z_valid = 1'b0;
    check("clr_x_valid", x_valid, 1'b0);
    check("clr_mask", cand_mask, 8'h01);
    check("clr_sticky", err_sticky, 1'b0);
    check("clr_ambig", ambig_cnt, 0);
    check("clr_err_cnt", err_cnt, 0);
    check("clr_sat_ambig", s_ambig_cnt, 0);
    check("clr_locked", locked, 1'b1);

    // Real encoder stream, restarted from 000 after clr and after a mid-stream reset.
    for (int pass = 0; pass < 2; pass++) begin
      enc_state = 0;
      for (int i = 0; i < 5000; i++) begin
        if ($urandom_range(0, 9) == 0) idle();
        else begin
          x = $urandom_range(0, 1);
          enc_state = tb_next(enc_state, x);
          issue(tb_z(enc_state), 1, x, enc_state);
        end
      end
      if (pass == 0) do_reset();
    end
    idle();
    check("ambig_many", ambig_cnt >= 16'd5, 1'b1);
    check("sat_ambig_saturated", s_ambig_cnt, 2'd3);

    idle();
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
